fwrisc_regfile_arb: RTL

Arbiter and sequencer sharing one register-file read port and one write port between two requesters: the core and the debug unit.
- Accepts one request at a time, one 32-bit read or write to a 6-bit register address (64 entries: GPRs plus CSR shadow space).
- Sequences the register file's 1-cycle synchronous read.
- Returns read data with a valid pulse to the owning requester.
- Sits between the core/debug logic and fwrisc_regfile.

---
 rtl/fwrisc_regfile_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fwrisc_regfile_arb.sv
// Arbiter/sequencer sharing one register-file read port and one write port between core and debug.
// Optional macro FWRISC_REGFILE_ARB_RR_EN: round-robin arbitration replaces core priority + starvation guard.
module fwrisc_regfile_arb #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  // Request handshake (both sides): req is the valid; the one-cycle gnt pulse is the ready.
  // req and its fields stay stable until gnt; req seen outside IDLE is ignored.
  input  logic        core_req,
  input  logic        core_we,
  input  logic [5:0]  core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [5:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic [5:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [5:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wen,
  output logic        busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        lat_id;   // owner of the op in flight: 1 = debug, 0 = core
  logic        lat_we;
  logic [5:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic        pick_dbg;
  logic        any_req;

  assign any_req = core_req | dbg_req;

`ifdef FWRISC_REGFILE_ARB_RR_EN
  logic        last_dbg;

  always_comb begin
    pick_dbg = dbg_req & ~core_req;
    if (core_req && dbg_req) begin
      pick_dbg = ~last_dbg;
    end
  end

  // Pointer starts on debug so the core takes the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_dbg <= 1'b1;
    end else if (state == ISSUE) begin
      last_dbg <= lat_id;
    end
  end
`else
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0]  starve;

  always_comb begin
    pick_dbg = dbg_req & ~core_req;
    if (core_req && dbg_req) begin
      pick_dbg = (starve == MAX_WAIT_C);
    end
  end

  // Counts arbitrations debug lost; never passes MAX_WAIT since debug then wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve <= 8'd0;
    end else if (state == ISSUE && lat_id) begin
      starve <= 8'd0;
    end else if (state == IDLE && core_req && dbg_req && !pick_dbg && starve != 8'hFF) begin
      starve <= starve + 8'd1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (any_req) state_nxt = ISSUE;
      ISSUE:     state_nxt = lat_we ? IDLE : READ_WAIT;
      READ_WAIT: state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 6'd0;
      lat_wdata <= 32'd0;
    end else if (state == IDLE && any_req) begin
      lat_id    <= pick_dbg;
      lat_we    <= pick_dbg ? dbg_we    : core_we;
      lat_addr  <= pick_dbg ? dbg_addr  : core_addr;
      lat_wdata <= pick_dbg ? dbg_wdata : core_wdata;
    end
  end

  // Read data lands one cycle after rf_raddr; each requester keeps its last result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      core_rdata <= 32'd0;
      dbg_rdata  <= 32'd0;
    end else if (state == READ_WAIT) begin
      if (lat_id) begin
        dbg_rdata <= rf_rdata;
      end else begin
        core_rdata <= rf_rdata;
      end
    end
  end

  always_comb begin
    core_gnt    = 1'b0;
    dbg_gnt     = 1'b0;
    core_rvalid = 1'b0;
    dbg_rvalid  = 1'b0;
    rf_raddr    = 6'd0;
    rf_waddr    = 6'd0;
    rf_wdata    = 32'd0;
    rf_wen      = 1'b0;
    if (state == ISSUE) begin
      core_gnt = ~lat_id;
      dbg_gnt  = lat_id;
      if (lat_we) begin
        rf_waddr = lat_addr;
        rf_wdata = lat_wdata;
        rf_wen   = (lat_addr != 6'd0);  // r0 writes are granted but dropped
      end else begin
        rf_raddr = lat_addr;
      end
    end
    if (state == RESP) begin
      core_rvalid = ~lat_id;
      dbg_rvalid  = lat_id;
    end
  end

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  a_gnt_onehot: assert property (@(posedge clock) disable iff (!reset)
    !(core_gnt && dbg_gnt));
  a_wen_issue: assert property (@(posedge clock) disable iff (!reset)
    rf_wen |-> (state == ISSUE));
  a_rvalid_onehot: assert property (@(posedge clock) disable iff (!reset)
    !(core_rvalid && dbg_rvalid));

endmodule
